// File: rtl/operand_fwd_ctrl.sv
// operand_fwd_ctrl: operand forwarding / load-use hazard controller.
// Tracks in-flight writers in EX, MEM and WB slots and drives the ALU
// operand-select codes (00 regfile, 01 EX, 10 MEM, 11 WB), plus the
// load-use stall and issue strobe.
// Build option: OPERAND_FWD_WB_BYPASS_EN enables forwarding from WB (code 11).
// Without it the regfile is write-before-read, so WB is tracked but never
// compared and code 11 is never produced.

`ifdef OPERAND_FWD_WB_BYPASS_EN
  `define OFC_NCMP 3
`else
  `define OFC_NCMP 2
`endif

// Per-source match/priority lane: one instance per ALU operand.
module fwd_src_sel #(
  parameter int REG_ADDR_W  = 3,
  parameter int ZERO_REG_EN = 1,
  parameter int NCMP        = `OFC_NCMP
) (
  input  logic [REG_ADDR_W-1:0]           i_rs,
  input  logic [NCMP-1:0]                 i_vld,
  input  logic [NCMP-1:0]                 i_we,
  input  logic [NCMP-1:0][REG_ADDR_W-1:0] i_rd,
  output logic                            o_match_ex,
  output logic [1:0]                      o_sel
);
  logic            w_nz;
  logic [NCMP-1:0] w_m;

  // register 0 never matches when it is hardwired to zero
  assign w_nz = (ZERO_REG_EN == 0) || (i_rs != '0);

  for (genvar s = 0; s < NCMP; s++) begin : g_cmp
    assign w_m[s] = i_vld[s] & i_we[s] & (i_rd[s] == i_rs) & w_nz;
  end

  assign o_match_ex = w_m[0];

  // youngest writer wins: EX, then MEM, then (optionally) WB
  always_comb begin
    o_sel = 2'b00;
    if (w_m[0])      o_sel = 2'b01;
    else if (w_m[1]) o_sel = 2'b10;
`ifdef OPERAND_FWD_WB_BYPASS_EN
    else if (w_m[2]) o_sel = 2'b11;
`endif
  end
endmodule

module operand_fwd_ctrl #(
  parameter int REG_ADDR_W  = 3,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_a,
  input  logic [REG_ADDR_W-1:0] id_rs_b,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b,
  output logic                  stall,
  output logic                  issue
);
  localparam int NSLOT = 3;          // 0 = ex, 1 = mem, 2 = wb
  localparam int NCMP  = `OFC_NCMP;  // slots taking part in forwarding

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } slot_t;

  slot_t r_slot [NSLOT];

  logic [1:0][REG_ADDR_W-1:0]      w_rs;
  logic [NCMP-1:0]                 w_vld;
  logic [NCMP-1:0]                 w_we;
  logic [NCMP-1:0][REG_ADDR_W-1:0] w_rd;
  logic [1:0]                      w_match_ex;
  logic [1:0][1:0]                 w_sel;
  logic                            w_hazard;

  assign w_rs = {id_rs_b, id_rs_a};

  // flatten the slots that are compared into packed lane inputs
  for (genvar s = 0; s < NCMP; s++) begin : g_flat
    assign w_vld[s] = r_slot[s].valid;
    assign w_we[s]  = r_slot[s].we;
    assign w_rd[s]  = r_slot[s].rd;
  end

  fwd_src_sel #(
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG_EN(ZERO_REG_EN),
    .NCMP       (NCMP)
  ) u_src [1:0] (
    .i_rs      (w_rs),
    .i_vld     (w_vld),
    .i_we      (w_we),
    .i_rd      (w_rd),
    .o_match_ex(w_match_ex),
    .o_sel     (w_sel)
  );

  // load in EX feeding either source: its data only exists after MEM
  assign w_hazard = id_valid & r_slot[0].is_load & (|w_match_ex);

  // flush kills the decode instruction, so it also cancels the stall
  always_comb begin
    stall = w_hazard & ~flush;
    issue = id_valid & ~w_hazard & ~flush;
    sel_a = w_hazard ? 2'b00 : w_sel[0];
    sel_b = w_hazard ? 2'b00 : w_sel[1];
  end

  // advance the scoreboard; a non-issuing cycle pushes a bubble into EX
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) r_slot[i] <= '0;
    end else begin
      r_slot[2] <= r_slot[1];
      r_slot[1] <= r_slot[0];
      r_slot[0] <= issue ? slot_t'{valid: 1'b1, we: id_rd_we, rd: id_rd, is_load: id_is_load}
                         : slot_t'('0);
    end
  end
endmodule

`undef OFC_NCMP

// File: tb/tb_operand_fwd_ctrl.sv
// Directed table-driven bench for operand_fwd_ctrl.
// Expected WB code depends on OPERAND_FWD_WB_BYPASS_EN.
module tb_operand_fwd_ctrl;
`ifdef OPERAND_FWD_WB_BYPASS_EN
  localparam logic [1:0] WB = 2'b11;
`else
  localparam logic [1:0] WB = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       rst, id_valid, id_rd_we, id_is_load, flush;
  logic [2:0] id_rs_a, id_rs_b, id_rd;
  logic [1:0] sel_a, sel_b;
  logic       stall, issue;

  int checks = 0;
  int errors = 0;

  operand_fwd_ctrl #(.REG_ADDR_W(3), .ZERO_REG_EN(1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_a(id_rs_a),
    .id_rs_b(id_rs_b), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .flush(flush), .sel_a(sel_a), .sel_b(sel_b),
    .stall(stall), .issue(issue)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst, v;
    logic [2:0] ra, rb, rd;
    bit         we, ld, fl;
    bit         chk, csel;
    logic [1:0] ea, eb;
    bit         es, ei;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, logic [2:0] ra, logic [2:0] rb,
                              logic [2:0] rd, bit we, bit ld, bit fl,
                              bit chk, bit csel, logic [1:0] ea,
                              logic [1:0] eb, bit es, bit ei);
    vec_t t;
    t.rst = r; t.v = v; t.ra = ra; t.rb = rb; t.rd = rd; t.we = we;
    t.ld = ld; t.fl = fl; t.chk = chk; t.csel = csel; t.ea = ea;
    t.eb = eb; t.es = es; t.ei = ei;
    return t;
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %b want %b", nm, idx, act, exp);
    end
  endtask

  // drive one cycle on the falling edge, check just after, edge follows
  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    rst = t.rst; id_valid = t.v; id_rs_a = t.ra; id_rs_b = t.rb;
    id_rd = t.rd; id_rd_we = t.we; id_is_load = t.ld; flush = t.fl;
    #1;
    if (t.chk) begin
      if (t.csel) begin
        cmp("sel_a", idx, sel_a, t.ea);
        cmp("sel_b", idx, sel_b, t.eb);
      end
      cmp("stall", idx, {1'b0, stall}, {1'b0, t.es});
      cmp("issue", idx, {1'b0, issue}, {1'b0, t.ei});
    end
  endtask

  vec_t tbl [30];
  vec_t hs  [8];

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs_a = '0; id_rs_b = '0; id_rd = '0;
    id_rd_we = 1'b0; id_is_load = 1'b0; flush = 1'b0;

    //          rst v  ra rb rd we ld fl chk csel ea     eb     st is
    // reset held with a writer presented: nothing recorded
    tbl[0]  = mk(1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tbl[2]  = mk(0, 0, 2, 2, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
    // issue rd=2, then read it from EX
    tbl[3]  = mk(0, 1, 0, 0, 2, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    tbl[4]  = mk(0, 1, 2, 0, 1, 0, 0, 0, 1, 1, 2'b01, 2'b00, 0, 1);
    // issue rd=2 again, reset in between, then read -> regfile
    tbl[5]  = mk(0, 1, 0, 0, 2, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tbl[7]  = mk(0, 1, 2, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    // ALU chain on r3: EX, MEM, WB, then gone
    tbl[8]  = mk(0, 1, 0, 0, 3, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    tbl[9]  = mk(0, 1, 3, 3, 0, 0, 0, 0, 1, 1, 2'b01, 2'b01, 0, 1);
    tbl[10] = mk(0, 1, 3, 1, 0, 0, 0, 0, 1, 1, 2'b10, 2'b00, 0, 1);
    tbl[11] = mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 1, WB,    2'b00, 0, 1);
    tbl[12] = mk(0, 0, 3, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
    // load-use on r5 via rs_b: one stall cycle then MEM forward
    tbl[13] = mk(0, 1, 0, 0, 5, 1, 1, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    tbl[14] = mk(0, 1, 1, 5, 7, 1, 0, 0, 1, 1, 2'b00, 2'b00, 1, 0);
    tbl[15] = mk(0, 1, 1, 5, 7, 1, 0, 0, 1, 1, 2'b00, 2'b10, 0, 1);
    // bubble sits in MEM: r7 in EX, load in WB
    tbl[16] = mk(0, 0, 5, 7, 0, 0, 0, 0, 1, 1, WB,    2'b01, 0, 0);
    // three writers of r4: youngest first
    tbl[17] = mk(0, 1, 0, 0, 4, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    tbl[18] = mk(0, 1, 0, 0, 4, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    tbl[19] = mk(0, 1, 0, 0, 4, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    tbl[20] = mk(0, 0, 4, 0, 0, 0, 0, 0, 1, 1, 2'b01, 2'b00, 0, 0);
    tbl[21] = mk(0, 1, 4, 0, 0, 0, 0, 0, 1, 1, 2'b10, 2'b00, 0, 1);
    // load to r0 never matches
    tbl[22] = mk(0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    tbl[23] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    // flush during load-use hazard on r6
    tbl[24] = mk(0, 1, 0, 0, 6, 1, 1, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    tbl[25] = mk(0, 1, 6, 0, 1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0);
    tbl[26] = mk(0, 0, 6, 1, 0, 0, 0, 0, 1, 1, 2'b10, 2'b00, 0, 0);
    tbl[27] = mk(0, 1, 6, 0, 0, 0, 0, 0, 1, 1, WB,    2'b00, 0, 1);
    // non-writer occupying EX does not match
    tbl[28] = mk(0, 1, 0, 0, 3, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    tbl[29] = mk(0, 1, 3, 3, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 1);

    for (int i = 0; i < 30; i++) apply(tbl[i], i);

    // reset mid-stall: the stall is dropped and the next cycle is clean
    hs[0] = mk(0, 1, 0, 0, 5, 1, 1, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    hs[1] = mk(1, 1, 5, 0, 2, 1, 0, 0, 1, 1, 2'b00, 2'b00, 1, 0);
    hs[2] = mk(0, 1, 5, 5, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    // stall and flush together: flush wins, EX gets a bubble
    hs[3] = mk(0, 1, 0, 0, 5, 1, 1, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    hs[4] = mk(0, 1, 0, 5, 2, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0);
    hs[5] = mk(0, 0, 2, 5, 0, 0, 0, 0, 1, 1, 2'b00, 2'b10, 0, 0);
    hs[6] = mk(0, 1, 0, 5, 0, 0, 0, 0, 1, 1, 2'b00, WB,    0, 1);
    hs[7] = mk(0, 0, 5, 5, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);

    for (int i = 0; i < 8; i++) apply(hs[i], 100 + i);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
